// File: rtl/data_mem_lsu.sv
// Data memory with an integrated RV32I load/store unit: one request in flight, response after LATENCY edges.
// Performs byte/half/word lane steering and extension, and reports illegal/misaligned/out-of-range accesses as faults.
module data_mem_lsu #(
    parameter int NUM_WORDS = 1024,
    parameter int ADDR_W    = 12,
    parameter int LATENCY   = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [1:0]        resp_fault_code
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-2:0] WORDS_LIM = (ADDR_W-1)'(NUM_WORDS);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_lsu: LATENCY must be >= 1");
    end
    if (NUM_WORDS * 4 > 2 ** ADDR_W) begin : g_bad_size
        $error("data_mem_lsu: NUM_WORDS*4 exceeds the byte address space");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_RANGE    = 2'd2,
        FC_ILLEGAL  = 2'd3
    } fault_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              complete;
    logic [CNT_W-1:0]  cnt;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [2:0]        cap_funct3;

    logic [31:0]       mem [NUM_WORDS];

    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic              legal;
    logic              misaligned;
    logic              out_of_range;
    fault_t            fault_code;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;
    logic [31:0]       st_mask;
    logic [31:0]       st_data;

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign complete = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= '0;
        end else if (accept) begin
            cnt        <= CNT_INIT;
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_funct3 <= req_funct3;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Decode of the captured request; evaluated only when it completes.
    always_comb begin
        word_idx     = cap_addr[ADDR_W-1:2];
        idx          = word_idx[IDX_W-1:0];
        rd_word      = mem[idx];
        legal        = cap_we ? (cap_funct3 inside {3'd0, 3'd1, 3'd2})
                              : (cap_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misaligned   = ((cap_funct3[1:0] == 2'd1) && cap_addr[0]) ||
                       ((cap_funct3[1:0] == 2'd2) && (cap_addr[1:0] != 2'b00));
        out_of_range = {1'b0, word_idx} >= WORDS_LIM;
        if (!legal) begin
            fault_code = FC_ILLEGAL;
        end else if (misaligned) begin
            fault_code = FC_MISALIGN;
        end else if (out_of_range) begin
            fault_code = FC_RANGE;
        end else begin
            fault_code = FC_NONE;
        end
    end

    always_comb begin
        ld_byte   = rd_word[{cap_addr[1:0], 3'b000} +: 8];
        ld_half   = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (cap_funct3)
            3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
            3'd2:    load_data = rd_word;
            3'd4:    load_data = {24'd0, ld_byte};
            3'd5:    load_data = {16'd0, ld_half};
            default: load_data = '0;
        endcase
    end

    // Store lanes: data is replicated across the word and the mask picks the addressed lanes.
    always_comb begin
        st_mask = '0;
        st_data = '0;
        case (cap_funct3[1:0])
            2'd0: begin
                st_mask = 32'h0000_00FF << {cap_addr[1:0], 3'b000};
                st_data = {4{cap_wdata[7:0]}};
            end
            2'd1: begin
                st_mask = cap_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                st_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                st_mask = '1;
                st_data = cap_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem <= '{default: '0};
        end else if (complete && cap_we && fault_code == FC_NONE) begin
            mem[idx] <= (rd_word & ~st_mask) | (st_data & st_mask);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_fault      <= 1'b0;
            resp_fault_code <= '0;
        end else begin
            resp_valid <= complete;
            if (complete) begin
                resp_rdata      <= (cap_we || fault_code != FC_NONE) ? '0 : load_data;
                resp_fault      <= (fault_code != FC_NONE);
                resp_fault_code <= fault_code;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: three instances (LATENCY 1/3/4, NUM_WORDS 1024/512/1024) sharing request fields.
// Expected responses are queued when a request is driven and compared when resp_valid pulses.
module tb_data_mem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              n_rst;
    logic              req_we;
    logic [11:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [2:0]        resp_valid;
    logic [2:0][31:0]  resp_rdata;
    logic [2:0]        resp_fault;
    logic [2:0][1:0]   resp_fault_code;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    exp_t sb_q[$];
    int   lat_of [3] = '{1, 3, 4};
    int   n_vec  = 0;
    int   n_fail = 0;

    data_mem_lsu #(.NUM_WORDS(1024), .ADDR_W(12), .LATENCY(1)) u0 (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
        .resp_fault_code(resp_fault_code[0])
    );

    data_mem_lsu #(.NUM_WORDS(512), .ADDR_W(12), .LATENCY(3)) u1 (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
        .resp_fault_code(resp_fault_code[1])
    );

    data_mem_lsu #(.NUM_WORDS(1024), .ADDR_W(12), .LATENCY(4)) u2 (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_fault(resp_fault[2]),
        .resp_fault_code(resp_fault_code[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge where the response is visible.
    task automatic txn(input int inst, input string tag, input logic we, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] exp_rd, input logic [1:0] exp_code, input bit hold);
        exp_t e;
        exp_t got;
        int   waited;
        int   n;
        e.rdata = exp_rd;
        e.fault = (exp_code != 2'd0);
        e.code  = exp_code;
        sb_q.push_back(e);

        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid[inst] = 1'b1;
        waited = 0;
        while (!req_ready[inst] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "/accept_wait"}, waited, 0);

        @(negedge clk);
        req_valid[inst] = hold;
        req_we     = 1'($urandom);
        req_addr   = 12'($urandom);
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        check({tag, "/pulse_low"}, 32'(resp_valid[inst]), 0);

        n = 0;
        while (!resp_valid[inst] && n < 50) begin
            check({tag, "/ready_busy"}, 32'(req_ready[inst]), 0);
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, n, lat_of[inst]);
        check({tag, "/ready_back"}, 32'(req_ready[inst]), 1);

        got = sb_q.pop_front();
        check({tag, "/rdata"}, resp_rdata[inst], got.rdata);
        check({tag, "/fault"}, 32'(resp_fault[inst]), 32'(got.fault));
        check({tag, "/code"}, 32'(resp_fault_code[inst]), 32'(got.code));
    endtask

    initial begin
        n_rst      = 1'b0;
        req_valid  = '0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset/ready", 32'(req_ready[i]), 1);
            check("reset/resp_valid", 32'(resp_valid[i]), 0);
            check("reset/rdata", resp_rdata[i], 0);
            check("reset/fault", 32'(resp_fault[i]), 0);
            check("reset/code", 32'(resp_fault_code[i]), 0);
        end
        n_rst = 1'b1;
        @(negedge clk);

        // Reset one edge after accepting a store on the LATENCY=3 instance.
        req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'hCAFE_BABE; req_funct3 = 3'd2;
        req_valid[1] = 1'b1;
        check("rst/ready_pre", 32'(req_ready[1]), 1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rst/busy", 32'(req_ready[1]), 0);
        @(posedge clk);
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("rst/ready_in_reset", 32'(req_ready[1]), 1);
        check("rst/valid_in_reset", 32'(resp_valid[1]), 0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rst/no_pulse", 32'(resp_valid[1]), 0);
            @(negedge clk);
        end
        txn(1, "rst_lw", 1'b0, 12'h020, 32'h0, 3'd2, 32'h0000_0000, 2'd0, 1'b0);

        // Byte lanes
        txn(0, "sb_101",  1'b1, 12'h101, 32'h0000_0080, 3'd0, 32'h0, 2'd0, 1'b0);
        txn(0, "lb_101",  1'b0, 12'h101, 32'h0, 3'd0, 32'hFFFF_FF80, 2'd0, 1'b0);
        txn(0, "lbu_101", 1'b0, 12'h101, 32'h0, 3'd4, 32'h0000_0080, 2'd0, 1'b0);
        txn(0, "lw_100",  1'b0, 12'h100, 32'h0, 3'd2, 32'h0000_8000, 2'd0, 1'b0);

        // Halfword lanes
        txn(0, "sh_202",  1'b1, 12'h202, 32'h0000_1234, 3'd1, 32'h0, 2'd0, 1'b0);
        txn(0, "lh_202",  1'b0, 12'h202, 32'h0, 3'd1, 32'h0000_1234, 2'd0, 1'b0);
        txn(0, "lw_200a", 1'b0, 12'h200, 32'h0, 3'd2, 32'h1234_0000, 2'd0, 1'b0);
        txn(0, "sh_200",  1'b1, 12'h200, 32'hFFFF_F00D, 3'd1, 32'h0, 2'd0, 1'b0);
        txn(0, "lhu_200", 1'b0, 12'h200, 32'h0, 3'd5, 32'h0000_F00D, 2'd0, 1'b0);
        txn(0, "lh_200",  1'b0, 12'h200, 32'h0, 3'd1, 32'hFFFF_F00D, 2'd0, 1'b0);
        txn(0, "lw_200b", 1'b0, 12'h200, 32'h0, 3'd2, 32'h1234_F00D, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold/rdata", resp_rdata[0], 32'h1234_F00D);
            check("hold/valid_low", 32'(resp_valid[0]), 0);
        end

        // Faults and priority
        txn(0, "sw_000",     1'b1, 12'h000, 32'h1122_3344, 3'd2, 32'h0, 2'd0, 1'b0);
        txn(0, "sw_003",     1'b1, 12'h003, 32'hFFFF_FFFF, 3'd2, 32'h0, 2'd1, 1'b0);
        txn(0, "lw_000a",    1'b0, 12'h000, 32'h0, 3'd2, 32'h1122_3344, 2'd0, 1'b0);
        txn(0, "lh_005",     1'b0, 12'h005, 32'h0, 3'd1, 32'h0, 2'd1, 1'b0);
        txn(0, "lw_003",     1'b0, 12'h003, 32'h0, 3'd2, 32'h0, 2'd1, 1'b0);
        txn(0, "ld_f3_3",    1'b0, 12'h000, 32'h0, 3'd3, 32'h0, 2'd3, 1'b0);
        txn(0, "ld_f3_3_mis",1'b0, 12'h001, 32'h0, 3'd3, 32'h0, 2'd3, 1'b0);
        txn(0, "st_f3_4",    1'b1, 12'h000, 32'hAAAA_AAAA, 3'd4, 32'h0, 2'd3, 1'b0);
        txn(0, "lw_000b",    1'b0, 12'h000, 32'h0, 3'd2, 32'h1122_3344, 2'd0, 1'b0);
        txn(0, "lw_800_ok",  1'b0, 12'h800, 32'h0, 3'd2, 32'h0, 2'd0, 1'b0);
        txn(0, "sw_ffc",     1'b1, 12'hFFC, 32'h0BAD_F00D, 3'd2, 32'h0, 2'd0, 1'b0);
        txn(0, "lw_ffc",     1'b0, 12'hFFC, 32'h0, 3'd2, 32'h0BAD_F00D, 2'd0, 1'b0);

        // Back-to-back with req_valid held; includes read-after-write
        txn(0, "b2b_sw",  1'b1, 12'h3FC, 32'hDEAD_BEEF, 3'd2, 32'h0, 2'd0, 1'b1);
        txn(0, "b2b_lw1", 1'b0, 12'h3FC, 32'h0, 3'd2, 32'hDEAD_BEEF, 2'd0, 1'b1);
        txn(0, "b2b_sb",  1'b1, 12'h3FD, 32'h0000_005A, 3'd0, 32'h0, 2'd0, 1'b1);
        txn(0, "b2b_lw2", 1'b0, 12'h3FC, 32'h0, 3'd2, 32'hDEAD_5AEF, 2'd0, 1'b0);

        // Range on the 512-word instance
        txn(1, "r_lw_800", 1'b0, 12'h800, 32'h0, 3'd2, 32'h0, 2'd2, 1'b0);
        txn(1, "r_sw_7fc", 1'b1, 12'h7FC, 32'h7777_8888, 3'd2, 32'h0, 2'd0, 1'b0);
        txn(1, "r_lw_7fc", 1'b0, 12'h7FC, 32'h0, 3'd2, 32'h7777_8888, 2'd0, 1'b0);
        txn(1, "r_sb_800", 1'b1, 12'h800, 32'h0000_0011, 3'd0, 32'h0, 2'd2, 1'b0);
        txn(1, "r_lw_802", 1'b0, 12'h802, 32'h0, 3'd2, 32'h0, 2'd1, 1'b0);
        txn(1, "r_st_f3_7",1'b1, 12'h801, 32'h0, 3'd7, 32'h0, 2'd3, 1'b0);
        txn(1, "r_lw_ffc", 1'b0, 12'hFFC, 32'h0, 3'd2, 32'h0, 2'd2, 1'b0);

        // LATENCY=4 instance
        txn(2, "l4_sw",  1'b1, 12'h010, 32'hA5A5_A5A5, 3'd2, 32'h0, 2'd0, 1'b0);
        txn(2, "l4_lw",  1'b0, 12'h010, 32'h0, 3'd2, 32'hA5A5_A5A5, 2'd0, 1'b0);
        txn(2, "l4_lb",  1'b0, 12'h012, 32'h0, 3'd0, 32'hFFFF_FFA5, 2'd0, 1'b0);
        txn(2, "l4_lhu", 1'b0, 12'h012, 32'h0, 3'd5, 32'h0000_A5A5, 2'd0, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised, handshaked data memory with an integrated load/store unit for the RV32I pipeline.
- Accepts one load or store per request.
- Completes each request after a configurable LATENCY, performing byte/half/word lane steering and sign or zero extension.
- Reports illegal, misaligned and out-of-range accesses as faults instead of silently corrupting memory.
- Sits in the MEM stage; the stall logic uses req_ready/resp_valid to freeze the pipeline.

Parameters:
- NUM_WORDS, 1024: number of 32-bit words in the array.
- ADDR_W, 12: byte-address width. NUM_WORDS*4 must be <= 2**ADDR_W.
- LATENCY, 1: edges from request acceptance to response (>=1). Values below 1 are illegal; flag with an elaboration-time error.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- req_funct3  in  3  RV32I load/store funct3
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  request faulted
- resp_fault_code  out  2  0 none, 1 misaligned, 2 out-of-range, 3 illegal funct3

Behaviour:
- Reset (async): state=IDLE, counter=0, all memory words=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, resp_fault_code=0.
- Reset mid-request drops the request. A pending store is never committed.
- FSM states: IDLE and BUSY.
- IDLE: req_ready=1. On a rising edge with req_valid&req_ready:
  - capture we, addr, wdata and funct3;
  - load counter with LATENCY-1;
  - go to BUSY.
- BUSY: req_ready=0; req_valid is ignored. At each edge, if counter!=0 the counter decrements. If counter==0, the edge does all of the following:
  - completes the access (store commit or registered read);
  - drives the response registers;
  - pulses resp_valid high for exactly one cycle;
  - returns to IDLE.
- Timing: with acceptance at edge k, completion happens at edge k+LATENCY and resp_valid is high during the cycle after that edge. req_ready is already 1 in that same cycle. Maximum throughput is one request per LATENCY+1 cycles.
- No response backpressure: the consumer must sample the resp_valid pulse.
- Ordering: requests are fully serialised. A load issued after a store to the same address returns the stored data.
- Legal funct3:
  - loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu;
  - stores: 0 sb, 1 sh, 2 sw;
  - anything else is illegal.
- Alignment: halfword accesses require addr[0]==0. Word accesses require addr[1:0]==00.
- Range: a request is out-of-range if addr[ADDR_W-1:2] >= NUM_WORDS.
- Fault priority: illegal > misaligned > out-of-range.
- On a fault: memory unchanged, resp_rdata=0, resp_fault=1, resp_fault_code set.
- Store lane steering (only the addressed lanes change):
  - sb: lane addr[1:0] <= wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0], little-endian.
  - sw: all four lanes <= wdata.
- Load extraction:
  - lb/lbu: byte at lane addr[1:0], sign- or zero-extended to 32.
  - lh/lhu: halfword at addr[1], sign- or zero-extended to 32.
  - lw: full word.
- Successful store: resp_rdata=0, resp_fault=0.
- resp_rdata, resp_fault and resp_fault_code hold their values until the next completion.

Test Plan:
- Reset mid-operation: LATENCY=3, accept sw 0xCAFEBABE at addr 0x020, assert n_rst low one edge later -> resp_valid never pulses; a later lw 0x020 returns 0x00000000.
- Byte stores then loads: sb 0x80 at 0x101, then lb 0x101 -> 0xFFFFFF80; lbu 0x101 -> 0x00000080; lw 0x100 -> 0x00008000.
- Halfword stores then loads: sh 0x1234 at 0x202, then lh 0x202 -> 0x00001234; lw 0x200 -> 0x12340000; then sh 0xF00D at 0x200 and lhu 0x200 -> 0x0000F00D; lw 0x200 -> 0x1234F00D.
- Faults: sw at 0x003 -> fault code 1, word 0 unchanged; lh 0x005 -> fault code 1; funct3=3 load -> fault code 3; with NUM_WORDS=512, lw 0x800 -> fault code 2. Each fault response has resp_rdata=0.
- Handshake timing: LATENCY=1, hold req_valid continuously with 4 back-to-back requests -> acceptances every 2 cycles, resp_valid pulses 1 cycle each, req_ready low exactly during BUSY. LATENCY=4 -> response 4 edges after acceptance.
- Read-after-write ordering: sw 0xDEADBEEF at 0x3FC immediately followed by lw 0x3FC -> 0xDEADBEEF, no fault.
